// File: rtl/bp_nonsynth_io_cmd_arbiter.sv
// bp_nonsynth_io_cmd_arbiter
//
// Lets num_req_p nonsynth test drivers share one CCE I/O command channel.
// Examples of drivers are the NBF loader, a host config driver and a trace
// replayer. Commands are single-beat. The arbiter picks a requester round-robin
// and presents its command downstream in the same cycle. It records the
// source ID of every accepted command in an in-order FIFO. Each response is
// steered back to the requester at the head of that FIFO.
//
// Build option:
//   BP_NONSYNTH_IO_ARB_FIXED_PRIO_EN
//      Defined:   the lowest valid index always wins in IDLE.
//      Undefined: round-robin starting after the last grant.
//
// Parameters:
//   num_req_p           number of requesters (>= 2)
//   max_outstanding_p   ID FIFO depth, a power of 2 (>= 1)
//   cce_io_msg_width_p  width of one command / response message
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   req_io_cmd_i           per-requester commands, requester k at slice k
//   req_io_cmd_v_i         per-requester command valid
//   req_io_cmd_yumi_o      command consumed, one-hot or zero
//   req_io_resp_o          response data, broadcast to every requester
//   req_io_resp_v_o        response valid, one-hot to the owning requester
//   req_io_resp_ready_i    per-requester response ready
//   io_cmd_o / io_cmd_v_o  muxed command towards the processor
//   io_cmd_yumi_i          downstream consumed the command
//   io_resp_i / io_resp_v_i / io_resp_ready_o   response from the processor
//   outstanding_o          current ID FIFO occupancy
//   error_o                sticky protocol error, cleared only by reset

module bp_nonsynth_io_cmd_arbiter #(
   parameter int num_req_p          = 2,
   parameter int max_outstanding_p  = 4,
   parameter int cce_io_msg_width_p = 64,
   localparam int cce_io_msg_width_lp = cce_io_msg_width_p,
   localparam int req_id_width_lp     = (num_req_p > 1) ? $clog2(num_req_p) : 1,
   localparam int cnt_width_lp        = $clog2(max_outstanding_p + 1),
   localparam int ptr_width_lp        = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
) (
   input  logic                                     clk_i,
   input  logic                                     reset_i,
   input  logic [num_req_p*cce_io_msg_width_lp-1:0] req_io_cmd_i,
   input  logic [num_req_p-1:0]                     req_io_cmd_v_i,
   output logic [num_req_p-1:0]                     req_io_cmd_yumi_o,
   output logic [cce_io_msg_width_lp-1:0]           req_io_resp_o,
   output logic [num_req_p-1:0]                     req_io_resp_v_o,
   input  logic [num_req_p-1:0]                     req_io_resp_ready_i,
   output logic [cce_io_msg_width_lp-1:0]           io_cmd_o,
   output logic                                     io_cmd_v_o,
   input  logic                                     io_cmd_yumi_i,
   input  logic [cce_io_msg_width_lp-1:0]           io_resp_i,
   input  logic                                     io_resp_v_i,
   output logic                                     io_resp_ready_o,
   output logic [cnt_width_lp-1:0]                  outstanding_o,
   output logic                                     error_o
);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e                     state_q, state_d;
   logic [req_id_width_lp-1:0] lock_q, lock_d;
   logic [req_id_width_lp-1:0] last_q, last_d;
   logic [req_id_width_lp-1:0] fifo_q [max_outstanding_p];
   logic [req_id_width_lp-1:0] fifo_d [max_outstanding_p];
   logic [ptr_width_lp-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [cnt_width_lp-1:0]    count_q, count_d;
   logic                       error_q, error_d;

   logic                       any_v, full, empty, push, pop, cmd_v;
   logic                       found_hi, found_lo;
   logic [req_id_width_lp-1:0] id_hi, id_lo, arb_id, sel, head;

   assign any_v = |req_io_cmd_v_i;
   assign full  = (count_q == cnt_width_lp'(max_outstanding_p));
   assign empty = (count_q == '0);
   assign head  = fifo_q[rptr_q];

   // id_lo is the lowest valid index overall. id_hi is the lowest valid
   // index strictly above the last grant. Round-robin prefers id_hi and
   // wraps to id_lo.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      id_hi    = '0;
      id_lo    = '0;
      for (int i = 0; i < num_req_p; i++) begin
         if (req_io_cmd_v_i[i] && !found_lo) begin
            found_lo = 1'b1;
            id_lo    = req_id_width_lp'(i);
         end
         if (req_io_cmd_v_i[i] && !found_hi && (req_id_width_lp'(i) > last_q)) begin
            found_hi = 1'b1;
            id_hi    = req_id_width_lp'(i);
         end
      end
   end

`ifdef BP_NONSYNTH_IO_ARB_FIXED_PRIO_EN
   assign arb_id = id_lo;
`else
   assign arb_id = found_hi ? id_hi : id_lo;
`endif

   // Grant FSM. Once a command is shown downstream without being consumed,
   // it is locked. This keeps the command stable on io_cmd_o. Full is the
   // registered flag, so a pop in the same cycle cannot open a slot early.
   always_comb begin
      state_d = state_q;
      lock_d  = lock_q;
      last_d  = last_q;
      sel     = lock_q;
      cmd_v   = 1'b0;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_v && !full) begin
               sel   = arb_id;
               cmd_v = 1'b1;
               if (io_cmd_yumi_i) begin
                  push   = 1'b1;
                  last_d = arb_id;
               end else begin
                  lock_d  = arb_id;
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            sel   = lock_q;
            cmd_v = 1'b1;
            if (io_cmd_yumi_i) begin
               push    = 1'b1;
               last_d  = lock_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Muxing and one-hot decoding. The selected command is muxed onto
   // io_cmd_o. The command yumi is decoded to the grant and the response
   // valid to the FIFO head.
   always_comb begin
      io_cmd_o          = '0;
      req_io_cmd_yumi_o = '0;
      req_io_resp_v_o   = '0;
      io_resp_ready_o   = 1'b0;
      for (int i = 0; i < num_req_p; i++) begin
         if (sel == req_id_width_lp'(i)) begin
            io_cmd_o             = req_io_cmd_i[i*cce_io_msg_width_lp +: cce_io_msg_width_lp];
            req_io_cmd_yumi_o[i] = push;
         end
         if (head == req_id_width_lp'(i)) begin
            req_io_resp_v_o[i] = io_resp_v_i & ~empty;
            io_resp_ready_o    = ~empty & req_io_resp_ready_i[i];
         end
      end
   end

   assign io_cmd_v_o    = cmd_v;
   assign req_io_resp_o = io_resp_i;
   assign pop           = io_resp_v_i & io_resp_ready_o;

   // ID FIFO update. A push and a pop in the same cycle leave the occupancy
   // unchanged. The error flag catches two cases: a yumi with nothing
   // offered, and a response arriving with no command outstanding.
   always_comb begin
      fifo_d = fifo_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) begin
         fifo_d[wptr_q] = sel;
         wptr_d = (wptr_q == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = (rptr_q == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : rptr_q + 1'b1;
      end
      count_d = count_q + cnt_width_lp'(push) - cnt_width_lp'(pop);
      error_d = error_q | (io_cmd_yumi_i & ~cmd_v) | (io_resp_v_i & empty);
   end

   // State registers. FIFO contents need no reset because the pointers and
   // the count define which entries are live.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         lock_q  <= '0;
         last_q  <= req_id_width_lp'(num_req_p - 1);
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         lock_q  <= lock_d;
         last_q  <= last_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         error_q <= error_d;
      end
      fifo_q <= fifo_d;
   end

   assign outstanding_o = count_q;
   assign error_o       = error_q;

endmodule

// File: tb/tb_bp_nonsynth_io_cmd_arbiter.sv
module tb_bp_nonsynth_io_cmd_arbiter;

   localparam int N = 2;
   localparam int D = 4;
   localparam int W = 16;

   logic           clk;
   logic           reset;
   logic [N*W-1:0] req_cmd;
   logic [N-1:0]   req_v;
   logic [N-1:0]   yumi_o;
   logic [W-1:0]   resp_o;
   logic [N-1:0]   resp_v_o;
   logic [N-1:0]   resp_ready;
   logic [W-1:0]   io_cmd;
   logic           io_cmd_v;
   logic           io_cmd_yumi;
   logic [W-1:0]   io_resp;
   logic           io_resp_v;
   logic           io_resp_ready;
   logic [2:0]     outstanding;
   logic           error;

   int checks = 0;
   int errors = 0;
   int sb_owner[$];

   bp_nonsynth_io_cmd_arbiter #(
      .num_req_p(N),
      .max_outstanding_p(D),
      .cce_io_msg_width_p(W)
   ) dut (
      .clk_i(clk),
      .reset_i(reset),
      .req_io_cmd_i(req_cmd),
      .req_io_cmd_v_i(req_v),
      .req_io_cmd_yumi_o(yumi_o),
      .req_io_resp_o(resp_o),
      .req_io_resp_v_o(resp_v_o),
      .req_io_resp_ready_i(resp_ready),
      .io_cmd_o(io_cmd),
      .io_cmd_v_o(io_cmd_v),
      .io_cmd_yumi_i(io_cmd_yumi),
      .io_resp_i(io_resp),
      .io_resp_v_i(io_resp_v),
      .io_resp_ready_o(io_resp_ready),
      .outstanding_o(outstanding),
      .error_o(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [N-1:0] onehot(int k);
      logic [N-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(int k, logic [W-1:0] val);
      req_cmd[k*W +: W] = val;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      req_v       = '0;
      req_cmd     = '0;
      resp_ready  = '0;
      io_cmd_yumi = 1'b0;
      io_resp     = '0;
      io_resp_v   = 1'b0;
      sb_owner.delete();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #2;
      checks++;
      if (outstanding !== 3'd0 || error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: outstanding=%0d error=%b, want 0 0", outstanding, error);
      end
      checks++;
      if (yumi_o !== 2'b00 || resp_v_o !== 2'b00 || io_resp_ready !== 1'b0 || io_cmd_v !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: yumi=%b resp_v=%b resp_ready=%b cmd_v=%b, want 00 00 0 0",
                  yumi_o, resp_v_o, io_resp_ready, io_cmd_v);
      end
   endtask

   task automatic test_single_requester();
      int owner;
      logic [W-1:0] d;
      do_reset();
      for (int n = 0; n < 3; n++) begin
         req_v = 2'b01;
         set_cmd(0, 16'h0A00 + 16'(n));
         io_cmd_yumi = 1'b1;
         #2;
         checks++;
         if (io_cmd_v !== 1'b1 || io_cmd !== 16'h0A00 + 16'(n) || yumi_o !== 2'b01) begin
            errors++;
            $display("[TB] FAIL single_issue n=%0d: v=%b cmd=%h yumi=%b, want 1 %h 01",
                     n, io_cmd_v, io_cmd, yumi_o, 16'h0A00 + 16'(n));
         end
         sb_owner.push_back(0);
         step();
      end
      req_v = '0;
      io_cmd_yumi = 1'b0;
      #2;
      checks++;
      if (outstanding !== 3'd3) begin
         errors++;
         $display("[TB] FAIL single_occupancy: outstanding=%0d, want 3", outstanding);
      end
      step();
      for (int n = 0; n < 3; n++) begin
         d = 16'hB000 + 16'(n);
         io_resp_v = 1'b1;
         io_resp = d;
         resp_ready = 2'b11;
         #2;
         owner = sb_owner.pop_front();
         checks++;
         if (resp_v_o !== onehot(owner) || io_resp_ready !== 1'b1 || resp_o !== d) begin
            errors++;
            $display("[TB] FAIL single_resp n=%0d: resp_v=%b ready=%b data=%h, want %b 1 %h",
                     n, resp_v_o, io_resp_ready, resp_o, onehot(owner), d);
         end
         step();
      end
      io_resp_v = 1'b0;
      #2;
      checks++;
      if (outstanding !== 3'd0) begin
         errors++;
         $display("[TB] FAIL single_drain: outstanding=%0d, want 0", outstanding);
      end
   endtask

   task automatic test_alternate();
      int seq[N];
      int exp_last;
      int exp_g;
      int exp_cnt;
      int owner;
      logic [W-1:0] exp_cmd;
      do_reset();
      exp_last = N - 1;
      for (int k = 0; k < N; k++) begin
         seq[k] = 0;
         set_cmd(k, {4'(k), 12'(seq[k])});
      end
      for (int c = 0; c < 9; c++) begin
         req_v = (c < 8) ? 2'b11 : 2'b00;
         io_cmd_yumi = (c < 8);
         io_resp_v = (sb_owner.size() > 0);
         io_resp = 16'hC000 + 16'(c);
         resp_ready = 2'b11;
`ifdef BP_NONSYNTH_IO_ARB_FIXED_PRIO_EN
         exp_g = 0;
`else
         exp_g = (exp_last + 1) % N;
`endif
         exp_cmd = {4'(exp_g), 12'(seq[exp_g])};
         exp_cnt = sb_owner.size();
         #2;
         if (c < 8) begin
            checks++;
            if (io_cmd_v !== 1'b1 || io_cmd !== exp_cmd || yumi_o !== onehot(exp_g)) begin
               errors++;
               $display("[TB] FAIL alt_grant c=%0d: v=%b cmd=%h yumi=%b, want 1 %h %b",
                        c, io_cmd_v, io_cmd, yumi_o, exp_cmd, onehot(exp_g));
            end
         end
         checks++;
         if (outstanding !== 3'(exp_cnt)) begin
            errors++;
            $display("[TB] FAIL alt_occupancy c=%0d: outstanding=%0d, want %0d", c, outstanding, exp_cnt);
         end
         if (io_resp_v) begin
            owner = sb_owner.pop_front();
            checks++;
            if (resp_v_o !== onehot(owner) || io_resp_ready !== 1'b1) begin
               errors++;
               $display("[TB] FAIL alt_resp c=%0d: resp_v=%b ready=%b, want %b 1",
                        c, resp_v_o, io_resp_ready, onehot(owner));
            end
         end
         if (c < 8) begin
            sb_owner.push_back(exp_g);
            exp_last = exp_g;
            seq[exp_g]++;
            set_cmd(exp_g, {4'(exp_g), 12'(seq[exp_g])});
         end
         step();
      end
      io_resp_v = 1'b0;
   endtask

   task automatic test_lock_stall();
      do_reset();
      // The first command moves the last grant to 0. Plain round-robin
      // would therefore favour requester 1 during the stall.
      req_v = 2'b01;
      set_cmd(0, 16'h1110);
      io_cmd_yumi = 1'b1;
      #2;
      sb_owner.push_back(0);
      step();
      set_cmd(0, 16'h1111);
      set_cmd(1, 16'h2222);
      for (int c = 0; c < 5; c++) begin
         req_v = (c >= 2) ? 2'b11 : 2'b01;
         io_cmd_yumi = 1'b0;
         #2;
         checks++;
         if (io_cmd_v !== 1'b1 || io_cmd !== 16'h1111 || yumi_o !== 2'b00) begin
            errors++;
            $display("[TB] FAIL lock_hold c=%0d: v=%b cmd=%h yumi=%b, want 1 1111 00",
                     c, io_cmd_v, io_cmd, yumi_o);
         end
         step();
      end
      io_cmd_yumi = 1'b1;
      #2;
      checks++;
      if (io_cmd !== 16'h1111 || yumi_o !== 2'b01) begin
         errors++;
         $display("[TB] FAIL lock_release: cmd=%h yumi=%b, want 1111 01", io_cmd, yumi_o);
      end
      sb_owner.push_back(0);
      step();
      req_v = 2'b10;
      #2;
      checks++;
      if (io_cmd_v !== 1'b1 || io_cmd !== 16'h2222 || yumi_o !== 2'b10) begin
         errors++;
         $display("[TB] FAIL lock_next_grant: v=%b cmd=%h yumi=%b, want 1 2222 10", io_cmd_v, io_cmd, yumi_o);
      end
      sb_owner.push_back(1);
      step();
      req_v = '0;
      io_cmd_yumi = 1'b0;
   endtask

   task automatic test_full();
      int owner;
      do_reset();
      req_v = 2'b01;
      for (int n = 0; n < 4; n++) begin
         set_cmd(0, 16'h3000 + 16'(n));
         io_cmd_yumi = 1'b1;
         #2;
         checks++;
         if (io_cmd_v !== 1'b1 || yumi_o !== 2'b01) begin
            errors++;
            $display("[TB] FAIL full_fill n=%0d: v=%b yumi=%b, want 1 01", n, io_cmd_v, yumi_o);
         end
         sb_owner.push_back(0);
         step();
      end
      set_cmd(0, 16'h3004);
      io_cmd_yumi = 1'b0;
      #2;
      checks++;
      if (io_cmd_v !== 1'b0 || outstanding !== 3'd4 || yumi_o !== 2'b00) begin
         errors++;
         $display("[TB] FAIL full_block: v=%b outstanding=%0d yumi=%b, want 0 4 00", io_cmd_v, outstanding, yumi_o);
      end
      step();
      io_resp_v = 1'b1;
      io_resp = 16'hD000;
      resp_ready = 2'b11;
      #2;
      owner = sb_owner.pop_front();
      checks++;
      if (io_cmd_v !== 1'b0 || io_resp_ready !== 1'b1 || resp_v_o !== onehot(owner)) begin
         errors++;
         $display("[TB] FAIL full_pop_cycle: cmd_v=%b ready=%b resp_v=%b, want 0 1 %b",
                  io_cmd_v, io_resp_ready, resp_v_o, onehot(owner));
      end
      step();
      io_resp_v = 1'b0;
      io_cmd_yumi = 1'b1;
      #2;
      checks++;
      if (io_cmd_v !== 1'b1 || io_cmd !== 16'h3004 || yumi_o !== 2'b01 || outstanding !== 3'd3) begin
         errors++;
         $display("[TB] FAIL full_fifth: v=%b cmd=%h yumi=%b outstanding=%0d, want 1 3004 01 3",
                  io_cmd_v, io_cmd, yumi_o, outstanding);
      end
      sb_owner.push_back(0);
      step();
      req_v = '0;
      io_cmd_yumi = 1'b0;
      #2;
      checks++;
      if (outstanding !== 3'd4 || error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL full_refill: outstanding=%0d error=%b, want 4 0", outstanding, error);
      end
   endtask

   task automatic test_resp_backpressure();
      int owner;
      do_reset();
      req_v = 2'b10;
      set_cmd(1, 16'h4444);
      io_cmd_yumi = 1'b1;
      #2;
      checks++;
      if (yumi_o !== 2'b10) begin
         errors++;
         $display("[TB] FAIL bp_issue: yumi=%b, want 10", yumi_o);
      end
      sb_owner.push_back(1);
      step();
      req_v = '0;
      io_cmd_yumi = 1'b0;
      io_resp_v = 1'b1;
      io_resp = 16'hE000;
      resp_ready = 2'b01;
      for (int c = 0; c < 3; c++) begin
         #2;
         checks++;
         if (resp_v_o !== 2'b10 || io_resp_ready !== 1'b0 || outstanding !== 3'd1) begin
            errors++;
            $display("[TB] FAIL bp_stall c=%0d: resp_v=%b ready=%b outstanding=%0d, want 10 0 1",
                     c, resp_v_o, io_resp_ready, outstanding);
         end
         step();
      end
      resp_ready = 2'b10;
      #2;
      owner = sb_owner.pop_front();
      checks++;
      if (io_resp_ready !== 1'b1 || resp_v_o !== onehot(owner)) begin
         errors++;
         $display("[TB] FAIL bp_release: ready=%b resp_v=%b, want 1 %b", io_resp_ready, resp_v_o, onehot(owner));
      end
      step();
      io_resp_v = 1'b0;
      #2;
      checks++;
      if (outstanding !== 3'd0 || error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_drain: outstanding=%0d error=%b, want 0 0", outstanding, error);
      end
   endtask

   task automatic test_errors();
      do_reset();
      io_resp_v = 1'b1;
      resp_ready = 2'b11;
      #2;
      checks++;
      if (io_resp_ready !== 1'b0 || resp_v_o !== 2'b00 || error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_empty_resp: ready=%b resp_v=%b error=%b, want 0 00 0",
                  io_resp_ready, resp_v_o, error);
      end
      step();
      io_resp_v = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2;
         checks++;
         if (error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky c=%0d: error=%b, want 1", c, error);
         end
         step();
      end
      // Traffic followed by a mid-run reset clears both occupancy and error.
      req_v = 2'b01;
      set_cmd(0, 16'h5555);
      io_cmd_yumi = 1'b1;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      req_v = '0;
      io_cmd_yumi = 1'b0;
      #2;
      checks++;
      if (outstanding !== 3'd0 || error !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_reset_clear: outstanding=%0d error=%b, want 0 0", outstanding, error);
      end
      step();
      // A yumi with no command offered is a protocol error.
      io_cmd_yumi = 1'b1;
      step();
      io_cmd_yumi = 1'b0;
      #2;
      checks++;
      if (error !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_stray_yumi: error=%b, want 1", error);
      end
      // A reset while a requester is locked drops the lock.
      do_reset();
      req_v = 2'b01;
      set_cmd(0, 16'h6666);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      req_v = 2'b10;
      set_cmd(1, 16'h7777);
      io_cmd_yumi = 1'b1;
      #2;
      checks++;
      if (io_cmd_v !== 1'b1 || io_cmd !== 16'h7777 || yumi_o !== 2'b10) begin
         errors++;
         $display("[TB] FAIL err_lock_dropped: v=%b cmd=%h yumi=%b, want 1 7777 10", io_cmd_v, io_cmd, yumi_o);
      end
      step();
      req_v = '0;
      io_cmd_yumi = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      req_v       = '0;
      req_cmd     = '0;
      resp_ready  = '0;
      io_cmd_yumi = 1'b0;
      io_resp     = '0;
      io_resp_v   = 1'b0;
      test_reset();
      test_single_requester();
      test_alternate();
      test_lock_stall();
      test_full();
      test_resp_backpressure();
      test_errors();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_nonsynth_io_cmd_arbiter.md
Name: bp_nonsynth_io_cmd_arbiter

Overview:
- Shares one CCE I/O command channel between num_req_p requesters, e.g. the NBF loader, a host config driver and a trace replayer.
- Arbitrates round-robin and issues single-beat commands downstream.
- Records the source of every accepted command in an in-order ID FIFO and steers each response back to that source.
- Sits between the nonsynth test drivers and the processor's I/O command port in the testbench top.

Parameters:
- bp_params_p, e_bp_inv_cfg, processor config; derives cce_io_msg_width_lp.
- num_req_p, 2, number of requesters (>=2).
- max_outstanding_p, 4, ID FIFO depth = maximum commands awaiting response (>=1, power of 2).
- localparam req_id_width_lp, `BSG_SAFE_CLOG2(num_req_p).
- localparam cnt_width_lp, `BSG_SAFE_CLOG2(max_outstanding_p+1).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; synchronous, active-high
- req_io_cmd_i  in  num_req_p*cce_io_msg_width_lp  commands; requester k at slice k
- req_io_cmd_v_i  in  num_req_p  command valid per requester
- req_io_cmd_yumi_o  out  num_req_p  command consumed, one-hot or zero
- req_io_resp_o  out  cce_io_msg_width_lp  response broadcast to all requesters
- req_io_resp_v_o  out  num_req_p  response valid, one-hot to the owner
- req_io_resp_ready_i  in  num_req_p  requester can accept a response
- io_cmd_o  out  cce_io_msg_width_lp  muxed command
- io_cmd_v_o  out  1  command valid
- io_cmd_yumi_i  in  1  downstream consumed the command
- io_resp_i  in  cce_io_msg_width_lp  downstream response
- io_resp_v_i  in  1  response valid
- io_resp_ready_o  out  1  arbiter can accept the response
- outstanding_o  out  cnt_width_lp  current ID FIFO occupancy
- error_o  out  1  sticky protocol error

Behaviour:
- Reset values:
  - ID FIFO empty; outstanding_o=0; error_o=0.
  - Lock state IDLE; last-grant pointer = num_req_p-1, so requester 0 has first priority.
  - All outputs derived combinationally from these, so yumi_o=0, resp_v_o=0 and io_resp_ready_o=0 in the first cycle after reset.
- Requester protocol is valid-yumi: once req_io_cmd_v_i[k] is raised, that requester holds its valid and command stable until yumi.
- State machine, 2 states:
  - IDLE:
    - If any request is valid and the FIFO is not full, select the first valid index after the last-grant pointer, wrapping modulo num_req_p.
    - Drive io_cmd_o = that slice and io_cmd_v_o=1.
    - If io_cmd_yumi_i=1 in the same cycle: assert req_io_cmd_yumi_o[g], push g, set last-grant=g, stay IDLE.
    - Otherwise register g as the locked grant and go to LOCKED.
  - LOCKED: drive the locked requester's command with io_cmd_v_o=1, ignoring other requesters. On io_cmd_yumi_i: yumi it, push its ID, set last-grant, return to IDLE.
- Rules:
  - Zero-latency issue: request to io_cmd_v_o in the same cycle. A requester that is yumi'd can be re-granted no sooner than the next cycle, and only if it wins round-robin.
  - FIFO full: io_cmd_v_o=0 in IDLE. LOCKED is entered only with a free slot, so a locked command never sees full.
  - Response routing:
    - h = FIFO head.
    - req_io_resp_v_o[h] = io_resp_v_i & ~empty.
    - io_resp_ready_o = ~empty & req_io_resp_ready_i[h].
    - Pop when io_resp_v_i & io_resp_ready_o.
  - Same-cycle push and pop: both take effect and occupancy is unchanged. When full, a pop that cycle does not enable a push, since the grant is computed from the registered full flag.
  - Response while the FIFO is empty: io_resp_ready_o=0, nothing is routed, error_o set until reset.
  - io_cmd_yumi_i while io_cmd_v_o=0: ignored, error_o set.
  - Reset mid-operation: the FIFO is flushed and the lock is dropped. Responses still in flight after reset are flagged as error.
- Occupancy wraps on FIFO pointers only; counters never overflow by construction.

Optional Feature:
- Macro: BP_NONSYNTH_IO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest valid index always wins in IDLE and the last-grant pointer is not used. LOCKED behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Single requester 0 sends 3 writes with yumi held high -> issued one per cycle; FIFO holds {0,0,0}; 3 responses produce req_io_resp_v_o=2'b01 each; outstanding_o returns to 0.
- Both requesters continuously valid, yumi always 1, max_outstanding_p=4, responses returned immediately -> grants alternate 0,1,0,1 (fixed-priority build: 0,0,0,0); each response goes to its issuer in order.
- Downstream stalls yumi 5 cycles while requester 0 is locked; requester 1 raises valid on cycle 2 -> io_cmd_o stays on requester 0 until yumi; requester 1 is granted the next cycle.
- No responses returned, 5 commands offered -> 4 accepted, io_cmd_v_o=0 with outstanding_o=4; one response then lets the 5th issue next cycle.
- Head owner's req_io_resp_ready_i=0 for 3 cycles -> io_resp_ready_o=0, FIFO unchanged; on ready=1 the response pops.
- io_resp_v_i=1 with the FIFO empty -> io_resp_ready_o=0, error_o=1 and held; reset_i mid-traffic -> outstanding_o=0, error_o=0 next cycle.
